// File: rtl/mpu_seq_pkg.sv
// Shared types and constants for the matrix command sequencer.
package mpu_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, LA_REQ, LA_WAIT, LB_REQ, LB_WAIT,
    EX_REQ, EX_WAIT, ST_REQ, ST_WAIT, FIN
  } seq_state_e;

  localparam logic [1:0] BUF_A    = 2'd0;
  localparam logic [1:0] BUF_B    = 2'd1;
  localparam logic [1:0] BUF_C    = 2'd2;
  localparam logic [1:0] BUF_NONE = 2'd3;

  localparam int WORDS       = 13;
  localparam int LAST_OFFSET = 192;
endpackage

// File: rtl/matrix_sequencer_if.sv
// Command, memory, buffer and ALU handshake bundle around the sequencer.
interface matrix_sequencer_if #(parameter int ADDR_W = 6);
  logic              cmd_valid, cmd_ready, cmd_skip_b;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_base_a, cmd_base_b, cmd_base_c;
  logic              mem_start, mem_write_enabled, mem_done;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        buffer_id;
  logic [7:0]        buffer_offset;
  logic              buffer_write;
  logic              alu_start, alu_done, alu_dumping;
  logic [3:0]        alu_op;
  logic              busy, done, error;

  modport master (
    input  cmd_valid, cmd_op, cmd_skip_b, cmd_base_a, cmd_base_b, cmd_base_c,
           mem_done, alu_done,
    output cmd_ready, mem_start, mem_write_enabled, mem_address,
           buffer_id, buffer_offset, buffer_write,
           alu_start, alu_op, alu_dumping, busy, done, error
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_skip_b, cmd_base_a, cmd_base_b, cmd_base_c,
           mem_done, alu_done,
    input  cmd_ready, mem_start, mem_write_enabled, mem_address,
           buffer_id, buffer_offset, buffer_write,
           alu_start, alu_op, alu_dumping, busy, done, error
  );
endinterface

// File: rtl/matrix_sequencer_xfer_addr_gen.sv
// Word counter for one matrix transfer: wrapped address, bit offset, last-word flag.
module xfer_addr_gen #(
  parameter int ADDR_W = 6,
  parameter int WORDS  = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        offset,
  output logic              last
);
  localparam int KW = $clog2(WORDS);

  logic [KW-1:0] k_d, k_q;

  always_comb begin
    k_d = k_q;
    if (clr)      k_d = '0;
    else if (inc) k_d = k_q + KW'(1);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) k_q <= '0;
    else          k_q <= k_d;

  // Address arithmetic is ADDR_W wide so it wraps naturally.
  assign addr   = base + ADDR_W'(k_q);
  assign offset = 8'(k_q) << 4;
  assign last   = (k_q == KW'(WORDS - 1));
endmodule

// File: rtl/matrix_sequencer.sv
// Runs one matrix job per command: load A, optionally B, execute, store C.
module matrix_sequencer
  import mpu_seq_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int WORDS   = mpu_seq_pkg::WORDS,
  parameter int TIMEOUT = 255
) (
  input logic               clock,
  input logic               reset_n,
  matrix_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_d, state_q;
  logic [3:0]        op_d, op_q;
  logic              skip_d, skip_q, err_d, err_q;
  logic [ADDR_W-1:0] base_a_d, base_a_q, base_b_d, base_b_q, base_c_d, base_c_q;
  logic [WD_W-1:0]   wd_d, wd_q;
  logic              k_clr, k_inc, last, in_wait, xfer;
  logic [ADDR_W-1:0] base_sel, addr;
  logic [7:0]        offset;

  xfer_addr_gen #(.ADDR_W(ADDR_W), .WORDS(WORDS)) u_addr (
    .clock(clock), .reset_n(reset_n), .clr(k_clr), .inc(k_inc),
    .base(base_sel), .addr(addr), .offset(offset), .last(last)
  );

  assign in_wait = state_q inside {LA_WAIT, LB_WAIT, EX_WAIT, ST_WAIT};
  assign xfer    = state_q inside {LA_REQ, LA_WAIT, LB_REQ, LB_WAIT, ST_REQ, ST_WAIT};

  always_comb begin
    base_sel = base_c_q;
    if (state_q inside {LA_REQ, LA_WAIT})      base_sel = base_a_q;
    else if (state_q inside {LB_REQ, LB_WAIT}) base_sel = base_b_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    skip_d   = skip_q;
    err_d    = err_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    wd_d     = '0;
    k_clr    = 1'b0;
    k_inc    = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d     = bus.cmd_op;
        skip_d   = bus.cmd_skip_b;
        base_a_d = bus.cmd_base_a;
        base_b_d = bus.cmd_base_b;
        base_c_d = bus.cmd_base_c;
        err_d    = 1'b0;
        k_clr    = 1'b1;
        state_d  = LA_REQ;
      end
      LA_REQ:  state_d = LA_WAIT;
      LB_REQ:  state_d = LB_WAIT;
      EX_REQ:  state_d = EX_WAIT;
      ST_REQ:  state_d = ST_WAIT;
      LA_WAIT, LB_WAIT, ST_WAIT: if (bus.mem_done) begin
        if (last) begin
          k_clr = 1'b1;
          case (state_q)
            LA_WAIT: state_d = skip_q ? EX_REQ : LB_REQ;
            LB_WAIT: state_d = EX_REQ;
            default: state_d = FIN;
          endcase
        end else begin
          k_inc = 1'b1;
          case (state_q)
            LA_WAIT: state_d = LA_REQ;
            LB_WAIT: state_d = LB_REQ;
            default: state_d = ST_REQ;
          endcase
        end
      end
      EX_WAIT: if (bus.alu_done) state_d = ST_REQ;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Watchdog only runs while a wait state is held; any completion resets it.
    if (in_wait && state_d == state_q) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        k_clr   = 1'b1;
        state_d = FIN;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      wd_q     <= wd_d;
    end

  assign bus.cmd_ready         = (state_q == IDLE);
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == FIN);
  assign bus.error             = err_q;
  assign bus.mem_start         = state_q inside {LA_REQ, LB_REQ, ST_REQ};
  assign bus.mem_address       = xfer ? addr : '0;
  assign bus.mem_write_enabled = state_q inside {ST_REQ, ST_WAIT};
  assign bus.alu_dumping       = state_q inside {ST_REQ, ST_WAIT};
  assign bus.buffer_offset     = offset;
  assign bus.buffer_write      = (state_q inside {LA_WAIT, LB_WAIT}) && bus.mem_done;
  assign bus.alu_start         = (state_q == EX_REQ);
  assign bus.alu_op            = op_q;

  always_comb begin
    bus.buffer_id = BUF_NONE;
    if (state_q inside {LA_REQ, LA_WAIT})      bus.buffer_id = BUF_A;
    else if (state_q inside {LB_REQ, LB_WAIT}) bus.buffer_id = BUF_B;
    else if (state_q inside {ST_REQ, ST_WAIT}) bus.buffer_id = BUF_C;
  end
endmodule
